// File: rtl/recovery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : recovery_pkg
// Purpose  : Shared types and constants for the recovery-register snapshot
//            path (restore sequencer, voter, PC controller).
// Revision : 1.0 - initial release
// ============================================================================
package recovery_pkg;

    // Restore sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } rrs_state_e;

    // One-hot faulty-core identifiers, bit order {C,B,A}.
    localparam logic [2:0] CORE_A = 3'b001;
    localparam logic [2:0] CORE_B = 3'b010;
    localparam logic [2:0] CORE_C = 3'b100;

    // Snapshot layout: entry 0 is the PC, entries 1..31 are x1..x31.
    localparam int NUM_ENTRIES = 32;
    localparam int PC_ENTRY    = 0;
    localparam int REG_IDX_W   = 5;

    // Number of cores flagged in a fault mask.
    function automatic logic [1:0] mask_popcount(input logic [2:0] mask);
        mask_popcount = {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/recovery_restore_sequencer_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : restore_out_stage
// Purpose  : Single-entry valid/ready output register for the snapshot write
//            port. Loads a new word when told to, otherwise holds the current
//            word until the consumer accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module restore_out_stage
    import recovery_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 i_load,
    input  logic                 i_ready,
    input  logic [DATA_W-1:0]    i_data,
    input  logic [REG_IDX_W-1:0] i_addr,
    input  logic                 i_is_pc,
    output logic                 o_valid,
    output logic [DATA_W-1:0]    o_data,
    output logic [REG_IDX_W-1:0] o_addr,
    output logic                 o_is_pc
);

    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [REG_IDX_W-1:0] r_addr;
    logic                 r_is_pc;

    // Valid flag: set on load, cleared once the held word is accepted.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload: only changes on load, so it is frozen under backpressure.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_data  <= '0;
            r_addr  <= '0;
            r_is_pc <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_addr  <= i_addr;
            r_is_pc <= i_is_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_is_pc = r_is_pc;

endmodule
`default_nettype wire

// File: rtl/recovery_restore_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : recovery_restore_sequencer
// Purpose  : After the voter flags a single faulty core, reads the PC and
//            x1..x31 snapshot back from the recovery register and streams it
//            into that core while holding all three cores.
// Revision : 1.0 - initial release
// ============================================================================
module recovery_restore_sequencer
    import recovery_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          NUM_ENTRIES = recovery_pkg::NUM_ENTRIES,
    parameter logic [31:0] REC_BASE    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 start,
    input  logic [2:0]           fault_mask,
    output logic [31:0]          rec_addr,
    input  logic [DATA_W-1:0]    rec_rdata,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [2:0]           wr_core_sel,
    output logic                 wr_is_pc,
    output logic [4:0]           wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 core_hold,
    output logic                 done,
    output logic                 err
);

    // Index counter must be able to express NUM_ENTRIES after the last load.
    localparam int c_IDX_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ENTRIES - 1);
    localparam logic [c_IDX_W-1:0] c_PC_IDX   = c_IDX_W'(PC_ENTRY);

    rrs_state_e                 r_state;
    rrs_state_e                 w_state_nxt;
    logic [31:0]                r_rec_addr;
    logic [c_IDX_W-1:0]         r_idx;
    logic [2:0]                 r_core_sel;

    logic [1:0]                 w_mask_cnt;
    logic                       w_start_ok;
    logic                       w_load;
    logic                       w_last;
    logic                       w_handshake;
    logic                       w_wr_valid;
    logic [REG_IDX_W-1:0]       w_load_addr;
    logic                       w_load_is_pc;

    assign w_mask_cnt   = mask_popcount(fault_mask);
    assign w_start_ok   = (r_state == ST_IDLE) && start && (w_mask_cnt == 2'd1);
    // Refill the output register whenever it is empty or being drained.
    assign w_load       = (r_state == ST_STREAM) && (!w_wr_valid || wr_ready);
    assign w_last       = (r_idx == c_LAST_IDX);
    assign w_handshake  = w_wr_valid && wr_ready;
    assign w_load_addr  = REG_IDX_W'(r_idx);
    assign w_load_is_pc = (r_idx == c_PC_IDX);

    // State register.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        core_hold   = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_mask_cnt == 2'd1) begin
                        w_state_nxt = ST_STREAM;
                    end else if (w_mask_cnt != 2'd0) begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            ST_STREAM: begin
                core_hold = 1'b1;
                if (w_load && w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                core_hold = 1'b1;
                if (w_handshake) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                // Multiple faulty cores cannot be repaired; stay here until reset.
                core_hold = 1'b1;
                err       = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read address, entry index and target core; advance once per load.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_rec_addr <= REC_BASE;
            r_idx      <= '0;
            r_core_sel <= 3'b000;
        end else if (w_start_ok) begin
            r_rec_addr <= REC_BASE;
            r_idx      <= '0;
            r_core_sel <= fault_mask;
        end else if (w_load) begin
            r_rec_addr <= r_rec_addr + 32'd4;
            r_idx      <= r_idx + 1'b1;
        end
    end

    restore_out_stage #(
        .DATA_W (DATA_W)
    ) u_out_stage (
        .clk     (clk),
        .rst_in  (rst_in),
        .i_load  (w_load),
        .i_ready (wr_ready),
        .i_data  (rec_rdata),
        .i_addr  (w_load_addr),
        .i_is_pc (w_load_is_pc),
        .o_valid (w_wr_valid),
        .o_data  (wr_data),
        .o_addr  (wr_addr),
        .o_is_pc (wr_is_pc)
    );

    assign wr_valid    = w_wr_valid;
    assign rec_addr    = r_rec_addr;
    assign wr_core_sel = r_core_sel;

endmodule
`default_nettype wire

// File: tb/tb_recovery_restore_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_recovery_restore_sequencer
// Purpose  : Self-checking bench for the recovery restore sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recovery_restore_sequencer;

    localparam logic [31:0] TB_BASE = 32'h0000_0100;

    logic        clk;
    logic        rst_in;
    logic        start;
    logic [2:0]  fault_mask;
    logic [31:0] rec_addr;
    logic [31:0] rec_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_core_sel;
    logic        wr_is_pc;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        err;

    recovery_restore_sequencer #(
        .DATA_W      (32),
        .NUM_ENTRIES (32),
        .REC_BASE    (TB_BASE)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .start       (start),
        .fault_mask  (fault_mask),
        .rec_addr    (rec_addr),
        .rec_rdata   (rec_rdata),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_core_sel (wr_core_sel),
        .wr_is_pc    (wr_is_pc),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .core_hold   (core_hold),
        .done        (done),
        .err         (err)
    );

    // Recovery register model: snapshot[i] = A000_0000 + i.
    assign rec_rdata = 32'hA000_0000 + ((rec_addr - TB_BASE) >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic        is_pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic push_expect(input logic [2:0] mask);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.sel   = mask;
            e.is_pc = (i == 0);
            e.addr  = 5'(i);
            e.data  = 32'hA000_0000 + 32'(i);
            sb.push_back(e);
        end
    endtask

    // Monitor: every handshake pops one expected word; stalled outputs must hold.
    bit          have_stall = 0;
    logic [31:0] st_data;
    logic [31:0] st_raddr;
    logic [4:0]  st_addr;
    logic        st_is_pc;
    logic [2:0]  st_sel;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_in) begin
            have_stall = 0;
        end else begin
            if (have_stall) begin
                chk("stall_data", wr_data, st_data);
                chk("stall_addr", 32'(wr_addr), 32'(st_addr));
                chk("stall_is_pc", 32'(wr_is_pc), 32'(st_is_pc));
                chk("stall_sel", 32'(wr_core_sel), 32'(st_sel));
                chk("stall_rec_addr", rec_addr, st_raddr);
            end
            if (wr_valid && wr_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_core_sel", 32'(wr_core_sel), 32'(e.sel));
                    chk("wr_is_pc", 32'(wr_is_pc), 32'(e.is_pc));
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", wr_data, e.data);
                end
            end
            have_stall = wr_valid && !wr_ready;
            st_data    = wr_data;
            st_raddr   = rec_addr;
            st_addr    = wr_addr;
            st_is_pc   = wr_is_pc;
            st_sel     = wr_core_sel;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_rec_addr"}, rec_addr, TB_BASE);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_wr_core_sel"}, 32'(wr_core_sel), 32'd0);
        chk({tag, "_wr_is_pc"}, 32'(wr_is_pc), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_core_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Apply reset across one clock edge; leaves time at posedge+1.
    task automatic do_reset();
        rst_in = 1'b0;
        start = 1'b0;
        fault_mask = 3'b000;
        wr_ready = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst_in = 1'b1;
    endtask

    // Full restore: start issued now (at posedge+1), then the next edge is edge 0.
    task automatic run_stream(input logic [2:0] mask, input int stall_idx, input int stall_len,
                              input int repulse_at, input int exp_done);
        int e0;
        int stall_left;
        int guard;
        int rel;
        bit got_done;
        push_expect(mask);
        start = 1'b1;
        fault_mask = mask;
        wr_ready = 1'b1;
        e0 = edge_cnt + 1;
        @(posedge clk); #1;
        start = 1'b0;
        fault_mask = 3'b000;
        chk("hold_after_edge0", 32'(core_hold), 32'd1);
        chk("no_valid_edge0", 32'(wr_valid), 32'd0);
        chk("rec_addr_edge0", rec_addr, TB_BASE);
        stall_left = stall_len;
        got_done = 0;
        guard = 0;
        while (!got_done && guard < 200) begin
            rel = edge_cnt - e0;
            if (done) begin
                got_done = 1;
                chk("done_edge", 32'(rel), 32'(exp_done));
                chk("hold_low_at_done", 32'(core_hold), 32'd0);
            end else begin
                if (rel == 1) begin
                    chk("first_valid", 32'(wr_valid), 32'd1);
                    chk("first_is_pc", 32'(wr_is_pc), 32'd1);
                    chk("first_data", wr_data, 32'hA000_0000);
                    chk("rec_addr_edge1", rec_addr, TB_BASE + 32'd4);
                end
                if (stall_idx >= 0 && wr_valid && wr_addr == 5'(stall_idx) && stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
                if (repulse_at >= 0 && rel == repulse_at) begin
                    start = 1'b1;
                    fault_mask = 3'b001;
                end else begin
                    start = 1'b0;
                    fault_mask = 3'b000;
                end
                @(posedge clk); #1;
                guard++;
            end
        end
        if (!got_done) chk("done_timeout", 32'd0, 32'd1);
        start = 1'b0;
        fault_mask = 3'b000;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("hold_idle", 32'(core_hold), 32'd0);
        chk("valid_idle", 32'(wr_valid), 32'd0);
        chk("all_words_sent", 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        logic [2:0] mask;
        int         stall_idx;
        int         stall_len;
        int         repulse_at;
        int         exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int guard;
        vecs[0] = '{mask: 3'b010, stall_idx: -1, stall_len: 0, repulse_at: -1, exp_done: 33};
        vecs[1] = '{mask: 3'b010, stall_idx: 5,  stall_len: 3, repulse_at: -1, exp_done: 36};
        vecs[2] = '{mask: 3'b100, stall_idx: 31, stall_len: 1, repulse_at: -1, exp_done: 34};
        vecs[3] = '{mask: 3'b001, stall_idx: 0,  stall_len: 2, repulse_at: -1, exp_done: 35};
        vecs[4] = '{mask: 3'b010, stall_idx: -1, stall_len: 0, repulse_at: 10, exp_done: 33};

        rst_in = 1'b1;
        start = 1'b0;
        fault_mask = 3'b000;
        wr_ready = 1'b1;
        #2;
        do_reset();
        check_reset_values("reset");

        // Streaming scenarios from the table.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            run_stream(vecs[v].mask, vecs[v].stall_idx, vecs[v].stall_len,
                       vecs[v].repulse_at, vecs[v].exp_done);
        end

        // Multi-bit mask: sticky error, no writes, second start ignored.
        do_reset();
        start = 1'b1;
        fault_mask = 3'b011;
        @(posedge clk); #1;
        start = 1'b0;
        fault_mask = 3'b000;
        chk("err_set", 32'(err), 32'd1);
        chk("err_hold", 32'(core_hold), 32'd1);
        start = 1'b1;
        fault_mask = 3'b010;
        @(posedge clk); #1;
        start = 1'b0;
        fault_mask = 3'b000;
        repeat (4) begin
            chk("err_no_valid", 32'(wr_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_core_sel", 32'(wr_core_sel), 32'd0);
        rst_in = 1'b0;
        #1;
        chk("err_cleared_by_reset", 32'(err), 32'd0);
        chk("hold_cleared_by_reset", 32'(core_hold), 32'd0);
        @(posedge clk); #1;
        rst_in = 1'b1;

        // Three-bit mask also errors.
        start = 1'b1;
        fault_mask = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        fault_mask = 3'b000;
        chk("err_mask111", 32'(err), 32'd1);

        // Empty mask: ignored entirely.
        do_reset();
        start = 1'b1;
        fault_mask = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("mask000");

        // Reset while entry 10 is presented, then a fresh restore to core C.
        do_reset();
        push_expect(3'b010);
        start = 1'b1;
        fault_mask = 3'b010;
        @(posedge clk); #1;
        start = 1'b0;
        fault_mask = 3'b000;
        guard = 0;
        while (!(wr_valid && wr_addr == 5'd10) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reached_entry10", 32'(wr_addr), 32'd10);
        rst_in = 1'b0;
        #1;
        chk("midreset_valid", 32'(wr_valid), 32'd0);
        chk("midreset_hold", 32'(core_hold), 32'd0);
        chk("midreset_rec_addr", rec_addr, TB_BASE);
        sb.delete();
        @(posedge clk); #1;
        rst_in = 1'b1;
        run_stream(3'b100, -1, 0, -1, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/recovery_restore_sequencer.md
# recovery_restore_sequencer

Reads the architectural snapshot (PC plus x1..x31) back out of the recovery register after the voter flags a single faulty core. It streams that snapshot into the faulty core over a valid/ready write port while holding all three cores. It sits between Voter/PC_Controller (fault indication) and the Main_core register-file and PC reload ports. It is the read-back counterpart of the recovery-register write path.

## Interface
Parameters:
- DATA_W, 32, snapshot word width
- NUM_ENTRIES, 32, snapshot words: entry 0 = PC, entries 1..31 = x1..x31
- REC_BASE, 32'h0000_0000, byte address of entry 0 in the recovery register

Ports:
- clk  in  1  single clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- fault_mask  in  3  faulty core one-hot {C,B,A}; sampled with start
- rec_addr  out  32  recovery-register read byte address
- rec_rdata  in  DATA_W  recovery-register read data, combinational from rec_addr
- wr_valid  out  1  snapshot word presented
- wr_ready  in  1  target core accepts word
- wr_core_sel  out  3  one-hot target core (= latched fault_mask)
- wr_is_pc  out  1  current word is the PC
- wr_addr  out  5  register index (0 when wr_is_pc)
- wr_data  out  DATA_W  snapshot word
- core_hold  out  1  freezes all three cores while high
- done  out  1  one-cycle pulse at successful completion
- err  out  1  sticky invalid-mask flag

## Operation
- States: IDLE, STREAM, DRAIN, DONE, ERROR.
- IDLE + start + one-hot mask:
  - latch mask
  - rec_addr = REC_BASE
  - entry index = 0
  - core_hold = 1
  - go to STREAM
- IDLE + start + mask 000: ignored.
- IDLE + start + mask with 2 or 3 bits set: go to ERROR.
  - err = 1 and core_hold = 1 until reset; no writes are issued.
- STREAM:
  - Output register loads rec_rdata when (!wr_valid || wr_ready) and entries remain.
  - On each load: rec_addr += 4, index += 1.
  - wr_is_pc = (index of held word == 0); wr_addr = held index[4:0].
- After the final entry loads, go to DRAIN. Leave DRAIN on the final handshake, then go to DONE.
- DONE: done = 1 and core_hold = 0 for one cycle, then IDLE.
- Backpressure: while wr_valid && !wr_ready, wr_data, wr_addr, wr_is_pc, wr_core_sel and rec_addr are stable.
- start while not IDLE: ignored.
- x0 is never written; NUM_ENTRIES words are sent in order 0..NUM_ENTRIES-1.

## Timing
- Reset values: rec_addr = REC_BASE, wr_valid = 0, wr_core_sel = 0, wr_is_pc = 0, wr_addr = 0, wr_data = 0, core_hold = 0, done = 0, err = 0, state IDLE.
- Reset mid-stream clears everything immediately. wr_valid drops asynchronously and no partial-word handshake completes.
- Start sampled at edge 0:
  - core_hold high after edge 0.
  - First wr_valid (PC) after edge 1.
- With wr_ready held high, transfers complete at edges 2..33 (32 words).
- done is high in the cycle after edge 33, concurrent with core_hold falling.
- Each low-ready cycle extends completion by exactly one cycle.
- Throughput is one word per cycle; latency from start to first word is 2 cycles.

## Structure
- Shared package recovery_pkg holds:
  - state enum
  - fault-mask constants (CORE_A = 3'b001, CORE_B = 3'b010, CORE_C = 3'b100)
  - NUM_ENTRIES and the snapshot layout (PC_ENTRY = 0)
- Voter and PC_Controller import the same package.
- One sub-module is natural: restore_out_stage, the single-entry valid/ready output register with load/hold logic. The FSM and address counter stay in the top module.

## Test plan
- Reset, start=1, mask=3'b010, ready=1, snapshot[i]=32'hA000_0000+i:
  - 32 writes, wr_core_sel=010.
  - First word has wr_is_pc=1 and data A000_0000.
  - Last word has wr_addr=31 and data A000_001F.
  - done after edge 33, core_hold low.
- Same stimulus but ready low for 3 cycles on entry 5: outputs stable during stall, entry 5 sent exactly once, done after edge 36.
- start with mask=3'b011: err=1, core_hold=1, no wr_valid.
  - A second start is ignored.
  - err clears only after rst_in low.
- start with mask=000: no state change, all outputs remain at reset values.
- rst_in asserted low at entry 10: wr_valid and core_hold go 0 immediately.
  - After release, a fresh start with mask 100 begins again at PC with rec_addr=REC_BASE.
- start re-pulsed with mask 001 mid-stream: ignored, stream completes to core B unchanged.
